// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button conditioner:
//   - btn_state_t   : per-channel FSM encoding (IDLE, PRESSED, HELD)
//   - DEF_*         : default parameter values used by the top level
//   - cnt_width()   : width needed for a counter that must hold 0..max_value
// ---------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_t;

  localparam int DEF_N               = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_HOLD_CYCLES     = 1000;
  localparam int DEF_REPEAT_CYCLES   = 250;

  // $clog2(max_value + 1), never narrower than one bit.
  function automatic int cnt_width(input int max_value);
    int w;
    w = $clog2(max_value + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_channel.sv
// ---------------------------------------------------------------------------
// button_channel
// One button channel: synchroniser, debounce counter, press/hold FSM and
// optional auto-repeat generator. All outputs are registered.
//
// Optional feature macro: BUTTON_REPEAT_EN
//   defined   -> auto_repeat pulses on long press, then every REPEAT_CYCLES
//   undefined -> auto_repeat is constant 0 and no repeat counter exists
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   btn          in   raw asynchronous button level (1 = pressed)
//   level        out  debounced button level
//   press        out  1-cycle pulse on accepted 0->1
//   released     out  1-cycle pulse on accepted 1->0
//   long_press   out  1-cycle pulse HOLD_CYCLES after the press pulse
//   auto_repeat  out  auto-repeat pulse train while held
// ---------------------------------------------------------------------------
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press,
  output logic released,
  output logic long_press,
  output logic auto_repeat
);

  localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(HOLD_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [DB_W-1:0]        db_cnt;
  logic [HOLD_W-1:0]      hold_cnt;
  btn_state_t             state;
  logic                   accept;
  logic                   rise;
  logic                   fall;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, giving a true shift register here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A change is accepted on the cycle that would bring the count of
  // consecutive differing samples up to DEBOUNCE_CYCLES.
  assign accept = (s != level) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign rise   = accept &&  s;
  assign fall   = accept && !s;

`ifdef BUTTON_REPEAT_EN
  localparam int REP_W = cnt_width(REPEAT_CYCLES);
  logic [REP_W-1:0] rep_cnt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level      <= 1'b0;
      press      <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
      db_cnt     <= '0;
      hold_cnt   <= '0;
      state      <= ST_IDLE;
`ifdef BUTTON_REPEAT_EN
      auto_repeat <= 1'b0;
      rep_cnt     <= '0;
`endif
    end else begin
      press      <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
`ifdef BUTTON_REPEAT_EN
      auto_repeat <= 1'b0;
`endif

      // Debounce: any cycle agreeing with level restarts the count.
      if (s == level) begin
        db_cnt <= '0;
      end else if (accept) begin
        level    <= s;
        db_cnt   <= '0;
        press    <= s;
        released <= !s;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      // An accepted fall overrides anything the FSM would do this cycle,
      // so no long_press or repeat can coincide with the release pulse.
      if (fall) begin
        state    <= ST_IDLE;
        hold_cnt <= '0;
`ifdef BUTTON_REPEAT_EN
        rep_cnt  <= '0;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise) begin
              state    <= ST_PRESSED;
              hold_cnt <= '0;
            end
          end
          ST_PRESSED: begin
            if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
              long_press <= 1'b1;
              state      <= ST_HELD;
              hold_cnt   <= HOLD_W'(HOLD_CYCLES);  // saturate
`ifdef BUTTON_REPEAT_EN
              auto_repeat <= 1'b1;
              rep_cnt     <= '0;
`endif
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          ST_HELD: begin
`ifdef BUTTON_REPEAT_EN
            if (rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
              auto_repeat <= 1'b1;
              rep_cnt     <= '0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
`endif
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifndef BUTTON_REPEAT_EN
  assign auto_repeat = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// N independent button channels, each synchronised, debounced and turned
// into press / release / long-press / auto-repeat pulses.
//
// Optional feature macro: BUTTON_REPEAT_EN (auto-repeat; otherwise the
// auto_repeat outputs are constant 0).
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   btn          in   [N] raw asynchronous button levels (1 = pressed)
//   level        out  [N] debounced levels
//   press        out  [N] 1-cycle pulse on accepted 0->1
//   released     out  [N] 1-cycle pulse on accepted 1->0
//   long_press   out  [N] 1-cycle pulse when held HOLD_CYCLES
//   auto_repeat  out  [N] auto-repeat pulses
// ---------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int N               = DEF_N,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] released,
  output logic [N-1:0] long_press,
  output logic [N-1:0] auto_repeat
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .btn        (btn[i]),
      .level      (level[i]),
      .press      (press[i]),
      .released   (released[i]),
      .long_press (long_press[i]),
      .auto_repeat(auto_repeat[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
// Directed bench: N=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10,
// REPEAT_CYCLES=3. Repeat expectations follow BUTTON_REPEAT_EN.
// Inputs change 1 time unit after a rising edge; "edge t" is the t-th rising
// edge after that change, and outputs are sampled 1 unit after that edge.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

`ifdef BUTTON_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] btn;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] released;
  logic [3:0] long_press;
  logic [3:0] auto_repeat;

  int checks;
  int errors;

  button_conditioner #(
    .N              (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .level      (level),
    .press      (press),
    .released   (released),
    .long_press (long_press),
    .auto_repeat(auto_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] obs;
    reset = 1'b1;
    btn   = '0;
    tick();
    tick();
    obs = {level, press, released, long_press, auto_repeat};
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL reset_state got %h want %h", obs, 20'h0);
    end
    reset = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      obs = {level, press, released, long_press, auto_repeat};
      checks++;
      if (obs !== 20'h0) begin
        errors++;
        $display("FAIL idle_after_reset t=%0d got %h want %h", t, obs, 20'h0);
      end
    end
  endtask

  task automatic test_press_release();
    logic [2:0] obs, exp;
    btn[0] = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      obs = {level[0], press[0], released[0]};
      exp = {t >= 6, t == 6, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL press0 t=%0d got %b want %b", t, obs, exp);
      end
    end
    btn[0] = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      obs = {level[0], press[0], released[0]};
      exp = {t < 6, 1'b0, t == 6};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL release0 t=%0d got %b want %b", t, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [2:0] obs;
    for (int k = 0; k < 5; k++) begin
      btn[1] = 1'b1;
      for (int t = 0; t < 6; t++) begin
        if (t == 3) btn[1] = 1'b0;
        tick();
        obs = {level[1], press[1], released[1]};
        checks++;
        if (obs !== 3'b000) begin
          errors++;
          $display("FAIL glitch1 k=%0d t=%0d got %b want 000", k, t, obs);
        end
      end
    end
    for (int t = 0; t < 4; t++) begin
      tick();
      obs = {level[1], press[1], released[1]};
      checks++;
      if (obs !== 3'b000) begin
        errors++;
        $display("FAIL glitch1_tail t=%0d got %b want 000", t, obs);
      end
    end
  endtask

  // Press at edge 6, long_press and first repeat at 16, repeats every 3.
  // Button falls after edge 31, so release lands at edge 37, which is also
  // where a repeat would have landed: the release must win.
  task automatic test_long_press_repeat();
    logic [4:0] obs, exp;
    logic       rep;
    btn[2] = 1'b1;
    for (int t = 1; t <= 45; t++) begin
      tick();
      rep = REP_EN && (t >= 16) && (t < 37) && (((t - 16) % 3) == 0);
      obs = {level[2], press[2], released[2], long_press[2], auto_repeat[2]};
      exp = {(t >= 6) && (t < 37), t == 6, t == 37, t == 16, rep};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL hold2 t=%0d got %b want %b", t, obs, exp);
      end
      if (t == 31) btn[2] = 1'b0;
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [19:0] obs;
    logic [1:0]  o2, e2;
    btn[3] = 1'b1;
    for (int t = 1; t <= 19; t++) tick();
    o2 = {level[3], auto_repeat[3]};
    e2 = {1'b1, REP_EN};
    checks++;
    if (o2 !== e2) begin
      errors++;
      $display("FAIL held3_before_reset got %b want %b", o2, e2);
    end
    reset = 1'b1;
    #1;
    obs = {level, press, released, long_press, auto_repeat};
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL reset_async got %h want %h", obs, 20'h0);
    end
    tick();
    tick();
    obs = {level, press, released, long_press, auto_repeat};
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL reset_held got %h want %h", obs, 20'h0);
    end
    reset = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      o2 = {level[3], press[3]};
      e2 = {t >= 6, t == 6};
      checks++;
      if (o2 !== e2) begin
        errors++;
        $display("FAIL repress3 t=%0d got %b want %b", t, o2, e2);
      end
    end
    btn[3] = 1'b0;
    for (int t = 1; t <= 8; t++) tick();
    checks++;
    if (level !== 4'h0) begin
      errors++;
      $display("FAIL settle3 got %b want 0000", level);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] obs, exp;
    btn = 4'hF;
    for (int t = 1; t <= 7; t++) begin
      tick();
      obs = {level, press};
      exp = {(t >= 6) ? 4'hF : 4'h0, (t == 6) ? 4'hF : 4'h0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL simul_press t=%0d got %h want %h", t, obs, exp);
      end
    end
    btn = 4'h0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      obs = {level, released};
      exp = {(t < 6) ? 4'hF : 4'h0, (t == 6) ? 4'hF : 4'h0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL simul_release t=%0d got %h want %h", t, obs, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    btn    = '0;
    test_reset();
    test_press_release();
    test_glitch();
    test_long_press_repeat();
    test_reset_mid_hold();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised N-channel front end for raw push-button inputs, the successor to the single-channel rising-edge pulse generator. Each channel synchronises its input, debounces it with a stability counter, and emits single-cycle press and release pulses, plus a long-press pulse and an optional auto-repeat pulse train. It sits between the board pins and the game-control FSMs, replacing per-button edge logic.

## Interface
- N, 4, number of independent button channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a level change (≥1)
- HOLD_CYCLES, 1000, cycles of accepted-high level before long_press fires (≥2)
- REPEAT_CYCLES, 250, auto-repeat period after long press (≥1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clk
- btn  in  N  raw, asynchronous button levels (1 = pressed)
- level  out  N  debounced button level
- press  out  N  1-cycle pulse on accepted 0→1
- release  out  N  1-cycle pulse on accepted 1→0
- long_press  out  N  1-cycle pulse when held HOLD_CYCLES
- repeat  out  N  auto-repeat pulses (tied 0 without BUTTON_REPEAT_EN)

## Operation
- Channels are fully independent; no shared state, so simultaneous events on any subset are handled in parallel.
- Synchroniser: SYNC_STAGES flops; all reset to 0.
- Debounce: counter increments every cycle the synchronised value s differs from level; it clears on any cycle with s == level. When the count reaches DEBOUNCE_CYCLES, level takes s, the counter clears, and press (rising) or release (falling) pulses.
- Glitches shorter than DEBOUNCE_CYCLES produce no output.
- Per-channel FSM:
  - IDLE (level=0): on accepted rise → PRESSED; hold counter := 0.
  - PRESSED: hold counter +1/cycle. When it reaches HOLD_CYCLES, pulse long_press → HELD.
  - HELD: with the macro, repeat counter runs; without it, the FSM idles in HELD.
  - Any accepted fall from PRESSED/HELD → IDLE; all counters clear. No long_press/repeat in or after that cycle.
- Counter widths: $clog2(max value + 1). Counters saturate and never wrap.
- Reset values: level, press, release, long_press, repeat = 0; FSM IDLE; all counters 0.
- Reset mid-operation aborts immediately with all outputs 0. A button still held at reset release is re-synchronised and re-debounced, yielding a fresh press.

## Timing
- btn change first sampled at edge 1. level, press or release update at edge SYNC_STAGES + DEBOUNCE_CYCLES (defaults: 18).
- press/release/long_press/repeat are registered and exactly one cycle wide.
- long_press is asserted HOLD_CYCLES cycles after the press cycle.
- repeat pulses coincide with long_press, then every REPEAT_CYCLES cycles while in HELD.
- DEBOUNCE_CYCLES = 1 degenerates to a synchronised edge detector with latency SYNC_STAGES + 1.

## Configuration
- BUTTON_REPEAT_EN defined: repeat counters and HELD-state pulse logic are present.
- BUTTON_REPEAT_EN undefined: the repeat port stays, driven constant 0. No repeat counters are synthesised; long_press is unaffected.

## Structure
- Package button_pkg holds:
  - FSM state encoding (IDLE, PRESSED, HELD)
  - default parameter constants
  - a counter-width helper function
- Sub-module button_channel contains the synchroniser, debounce counter, FSM and repeat logic for one channel. button_conditioner instantiates it N times via generate.

## Test plan
Configuration for all scenarios: N=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, macro defined.

- btn[0] 0→1 at edge 0, held → level[0] and press[0] go 1 at edge 6; press[0] is high for exactly one cycle.
- btn[1] high 3 cycles then low, repeated 5 times → level[1] stays 0; no press/release.
- btn[2] held 30 cycles, press at cycle P → long_press[2] at P+10; repeat[2] at P+10, P+13, P+16, …
- btn[2] released after repeat → release[2] 6 cycles after fall; no further long_press/repeat; FSM IDLE.
- reset asserted while btn[3] is held in HELD → all outputs 0 at once. After deassert with btn[3] still high, press[3] fires at edge 6 again.
- All four btn rise on the same edge → four press bits assert in the same cycle. Rebuilt without the macro, repeat stays 0 throughout.
